// File: rtl/frame_ram_sched.sv
// rtl/frame_ram_sched.sv - frame tile RAM port scheduler with clear sweep
//
// Owns the single port of the 80x60 tile RAM. Video fetch reads always win.
// The three game-logic writers (head, tail, food) are granted round-robin in
// cycles where video does not need the port. After reset, or on clr_start,
// a sweep writes CLEAR_VAL to every tile before normal service resumes.
//
// Optional build macro: FRAME_WR_BOUNDS_CHK_EN
//   Drops granted writes with an address >= DEPTH and flags them on wr_oob.
//
// Ports:
//   px_clk     pixel clock, rising edge
//   rstn       synchronous active-low reset
//   vid_rd_en  video fetch needs the port this cycle
//   vid_addr   video fetch address
//   wr_req     write requests: bit0 head, bit1 tail, bit2 food
//   wr_addr    packed write addresses, slot k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data    packed write data, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_gnt     one-hot grant; the write happens in the grant cycle
//   clr_start  pulse: start a clear sweep (ignored while clr_busy)
//   clr_busy   clear sweep in progress
//   clr_done   one-cycle pulse after the last tile is cleared
//   ram_addr   RAM address
//   ram_write  RAM write enable
//   ram_wdata  RAM write data
//   wr_oob     (FRAME_WR_BOUNDS_CHK_EN only) granted write was out of range
`timescale 1ns/1ps

module frame_ram_sched #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4800,
  parameter int CLEAR_VAL  = 0
) (
  input  logic                    px_clk,
  input  logic                    rstn,
  input  logic                    vid_rd_en,
  input  logic [ADDR_WIDTH-1:0]   vid_addr,
  input  logic [2:0]              wr_req,
  input  logic [3*ADDR_WIDTH-1:0] wr_addr,
  input  logic [3*DATA_WIDTH-1:0] wr_data,
  output logic [2:0]              wr_gnt,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_write,
  output logic [DATA_WIDTH-1:0]   ram_wdata
`ifdef FRAME_WR_BOUNDS_CHK_EN
  ,
  output logic                    wr_oob
`endif
);

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
`ifdef FRAME_WR_BOUNDS_CHK_EN
  // One extra bit so DEPTH itself is representable for the unsigned compare.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
`endif

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [1:0]              ptr, ptr_nxt;
  logic                    done_nxt;

  logic                    pick_vld;
  logic [1:0]              pick;
  logic [2:0]              idx;
  logic [ADDR_WIDTH-1:0]   slot_addr;
  logic [DATA_WIDTH-1:0]   slot_data;

  // Round-robin search: first requester at or after ptr, wrapping 2 -> 0.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    idx      = 3'd0;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, ptr} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!pick_vld && wr_req[idx[1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[1:0];
      end
    end
  end

  assign slot_addr = wr_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
  assign slot_data = wr_data[pick*DATA_WIDTH +: DATA_WIDTH];
  assign clr_busy  = (state == CLEAR);

  always_ff @(posedge px_clk) begin
    if (!rstn) begin
      state    <= CLEAR;
      cnt      <= '0;
      ptr      <= 2'd0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      clr_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    wr_gnt    = 3'b000;
    ram_addr  = vid_addr;
    ram_write = 1'b0;
    ram_wdata = DATA_WIDTH'(CLEAR_VAL);
`ifdef FRAME_WR_BOUNDS_CHK_EN
    wr_oob    = 1'b0;
`endif
    // While reset is held the port is left idle (no writes, no grants).
    if (rstn) begin
      case (state)
        CLEAR: begin
          // Video reads take the port; the sweep simply stalls that cycle.
          if (!vid_rd_en) begin
            ram_write = 1'b1;
            ram_addr  = cnt;
            if (cnt == LAST_ADDR) begin
              state_nxt = SERVE;
              cnt_nxt   = '0;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt + ADDR_WIDTH'(1);
            end
          end
        end
        SERVE: begin
          if (clr_start) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
          end else if (!vid_rd_en && pick_vld) begin
            wr_gnt[pick] = 1'b1;
            ram_write    = 1'b1;
            ram_addr     = slot_addr;
            ram_wdata    = slot_data;
            ptr_nxt      = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
`ifdef FRAME_WR_BOUNDS_CHK_EN
            // Grant still consumed so the requester can move on.
            if ({1'b0, slot_addr} >= DEPTH_W) begin
              ram_write = 1'b0;
              wr_oob    = 1'b1;
            end
`endif
          end
        end
        default: state_nxt = CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_ram_sched.sv
// tb/tb_frame_ram_sched.sv - self-checking bench for frame_ram_sched
`timescale 1ns/1ps

module tb_frame_ram_sched;

  localparam int AW    = 13;
  localparam int DW    = 3;
  localparam int DEPTH = 4800;

  logic            px_clk = 1'b0;
  logic            rstn = 1'b0;
  logic            vid_rd_en = 1'b0;
  logic [AW-1:0]   vid_addr = '0;
  logic [2:0]      wr_req = 3'b000;
  logic [3*AW-1:0] wr_addr = '0;
  logic [3*DW-1:0] wr_data = '0;
  logic            clr_start = 1'b0;
  logic [2:0]      wr_gnt;
  logic            clr_busy;
  logic            clr_done;
  logic [AW-1:0]   ram_addr;
  logic            ram_write;
  logic [DW-1:0]   ram_wdata;
`ifdef FRAME_WR_BOUNDS_CHK_EN
  logic            wr_oob;
`endif

  frame_ram_sched dut (
    .px_clk    (px_clk),
    .rstn      (rstn),
    .vid_rd_en (vid_rd_en),
    .vid_addr  (vid_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_wdata (ram_wdata)
`ifdef FRAME_WR_BOUNDS_CHK_EN
    ,
    .wr_oob    (wr_oob)
`endif
  );

  always #5 px_clk = ~px_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: sweep position, round-robin pointer, done pulse.
  bit      m_clear;
  bit      m_done;
  int      m_cnt;
  int      m_ptr;
  // Expected port outputs for the current cycle.
  logic [2:0]    e_gnt;
  logic          e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          e_oob;
  int            e_k;

  function automatic void model_reset();
    m_clear = 1'b1;
    m_done  = 1'b0;
    m_cnt   = 0;
    m_ptr   = 0;
  endfunction

  function automatic void model_eval();
    e_gnt  = 3'b000;
    e_wr   = 1'b0;
    e_addr = vid_addr;
    e_wd   = '0;
    e_oob  = 1'b0;
    e_k    = -1;
    if (m_clear) begin
      if (!vid_rd_en) begin
        e_wr   = 1'b1;
        e_addr = AW'(m_cnt);
      end
    end else if (!clr_start && !vid_rd_en) begin
      for (int i = 0; i < 3; i++) begin
        automatic int k = (m_ptr + i) % 3;
        if (e_k < 0 && wr_req[k]) e_k = k;
      end
      if (e_k >= 0) begin
        e_gnt  = 3'(1 << e_k);
        e_addr = wr_addr[e_k*AW +: AW];
        e_wd   = wr_data[e_k*DW +: DW];
        e_wr   = 1'b1;
`ifdef FRAME_WR_BOUNDS_CHK_EN
        if (int'(e_addr) >= DEPTH) begin
          e_wr  = 1'b0;
          e_oob = 1'b1;
        end
`endif
      end
    end
  endfunction

  function automatic void model_commit();
    bit nd = 1'b0;
    if (m_clear) begin
      if (!vid_rd_en) begin
        if (m_cnt == DEPTH - 1) begin
          m_clear = 1'b0;
          m_cnt   = 0;
          nd      = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end else if (clr_start) begin
      m_clear = 1'b1;
      m_cnt   = 0;
    end else if (e_k >= 0) begin
      m_ptr = (e_k + 1) % 3;
    end
    m_done = nd;
  endfunction

  task automatic test_reset();
    wr_req  = 3'b111;
    wr_addr = {AW'(300), AW'(200), AW'(100)};
    wr_data = {DW'(3), DW'(2), DW'(1)};
    rstn    = 1'b0;
    @(posedge px_clk); #1;
    @(posedge px_clk); #2;
    total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", clr_done); end
    total++; if (wr_gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", wr_gnt); end
    total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", ram_write); end
    model_reset();
    rstn = 1'b1;
  endtask

  // Full sweep with requests held pending; counts busy cycles on the DUT.
  task automatic test_sweep();
    int  n = 0;
    bit  got_done = 1'b0;
    for (int c = 0; c < 6000 && !got_done; c++) begin
      #3;
      model_eval();
      total++;
      if ({wr_gnt, ram_write, ram_addr, ram_wdata, clr_busy, clr_done} !==
          {e_gnt, e_wr, e_addr, e_wd, m_clear, m_done}) begin
        bad++;
        $display("FAIL sweep c=%0d got gnt=%b wr=%b addr=%0d wd=%0d busy=%b done=%b exp gnt=%b wr=%b addr=%0d wd=%0d busy=%b done=%b",
                 c, wr_gnt, ram_write, ram_addr, ram_wdata, clr_busy, clr_done,
                 e_gnt, e_wr, e_addr, e_wd, m_clear, m_done);
      end
      if (clr_busy === 1'b1) n++;
      if (clr_done === 1'b1) got_done = 1'b1;
      model_commit();
      @(posedge px_clk); #1;
    end
    total++;
    if (!got_done || n != DEPTH) begin
      bad++;
      $display("FAIL sweep_len got busy=%0d done_seen=%0d exp busy=%0d done_seen=1", n, got_done, DEPTH);
    end
  endtask

  task automatic test_rr();
    logic [2:0] prev = 3'b000;
    vid_rd_en = 1'b0;
    wr_req    = 3'b111;
    wr_addr   = {AW'(4000), AW'(2500), AW'(1234)};
    wr_data   = {DW'(6), DW'(5), DW'(4)};
    for (int c = 0; c < 6; c++) begin
      #3;
      model_eval();
      total++;
      if ({wr_gnt, ram_write, ram_addr, ram_wdata, clr_busy, clr_done} !==
          {e_gnt, e_wr, e_addr, e_wd, m_clear, m_done}) begin
        bad++;
        $display("FAIL rr c=%0d got gnt=%b wr=%b addr=%0d wd=%0d exp gnt=%b wr=%b addr=%0d wd=%0d",
                 c, wr_gnt, ram_write, ram_addr, ram_wdata, e_gnt, e_wr, e_addr, e_wd);
      end
      if (c > 0) begin
        total++;
        if (wr_gnt !== {prev[1:0], prev[2]}) begin
          bad++;
          $display("FAIL rr_rotate c=%0d got=%b exp=%b", c, wr_gnt, {prev[1:0], prev[2]});
        end
      end
      prev = wr_gnt;
      model_commit();
      @(posedge px_clk); #1;
    end
  endtask

  task automatic test_video_block();
    wr_req    = 3'b010;
    wr_addr   = {AW'(0), AW'(2025), AW'(0)};
    wr_data   = {DW'(0), DW'(3), DW'(0)};
    vid_rd_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) vid_rd_en = 1'b0;
      vid_addr = AW'($urandom_range(0, DEPTH - 1));
      #3;
      model_eval();
      if (c < 5) begin
        total++;
        if (wr_gnt !== 3'b000 || ram_write !== 1'b0 || ram_addr !== vid_addr) begin
          bad++;
          $display("FAIL vid_block c=%0d got gnt=%b wr=%b addr=%0d exp gnt=000 wr=0 addr=%0d",
                   c, wr_gnt, ram_write, ram_addr, vid_addr);
        end
      end else begin
        total++;
        if (wr_gnt !== 3'b010 || ram_write !== 1'b1 || ram_addr !== AW'(2025) || ram_wdata !== DW'(3)) begin
          bad++;
          $display("FAIL vid_release got gnt=%b wr=%b addr=%0d wd=%0d exp gnt=010 wr=1 addr=2025 wd=3",
                   wr_gnt, ram_write, ram_addr, ram_wdata);
        end
      end
      model_commit();
      @(posedge px_clk); #1;
    end
    wr_req = 3'b000;
  endtask

  // clr_start with a pending head write; sweep stalled 10 cycles by video.
  task automatic test_clear_pending();
    int  n = 0;
    bit  got_done = 1'b0;
    wr_req    = 3'b001;
    wr_addr   = {AW'(0), AW'(0), AW'(77)};
    wr_data   = {DW'(0), DW'(0), DW'(5)};
    vid_rd_en = 1'b0;
    clr_start = 1'b1;
    #3;
    model_eval();
    total++;
    if (wr_gnt !== 3'b000 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL clr_start_cycle got gnt=%b wr=%b exp gnt=000 wr=0", wr_gnt, ram_write);
    end
    model_commit();
    @(posedge px_clk); #1;
    clr_start = 1'b0;
    for (int c = 0; c < 6000 && !got_done; c++) begin
      vid_rd_en = (c >= 2000 && c < 2010);
      vid_addr  = AW'($urandom_range(0, DEPTH - 1));
      clr_start = (c == 100);
      #3;
      model_eval();
      total++;
      if ({wr_gnt, ram_write, ram_addr, ram_wdata, clr_busy, clr_done} !==
          {e_gnt, e_wr, e_addr, e_wd, m_clear, m_done}) begin
        bad++;
        $display("FAIL clr_sweep c=%0d got gnt=%b wr=%b addr=%0d wd=%0d busy=%b done=%b exp gnt=%b wr=%b addr=%0d wd=%0d busy=%b done=%b",
                 c, wr_gnt, ram_write, ram_addr, ram_wdata, clr_busy, clr_done,
                 e_gnt, e_wr, e_addr, e_wd, m_clear, m_done);
      end
      if (clr_busy === 1'b1) n++;
      if (clr_done === 1'b1) begin
        got_done = 1'b1;
        total++;
        if (wr_gnt !== 3'b001 || ram_addr !== AW'(77)) begin
          bad++;
          $display("FAIL clr_first_grant got gnt=%b addr=%0d exp gnt=001 addr=77", wr_gnt, ram_addr);
        end
      end
      model_commit();
      @(posedge px_clk); #1;
    end
    clr_start = 1'b0;
    total++;
    if (!got_done || n != DEPTH + 10) begin
      bad++;
      $display("FAIL clr_sweep_len got busy=%0d done_seen=%0d exp busy=%0d done_seen=1", n, got_done, DEPTH + 10);
    end
    wr_req = 3'b000;
  endtask

  // Randomized traffic with the requester handshake and a fairness watch.
  task automatic test_random();
    logic [2:0] granted = 3'b000;
    int         last_k = -1;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!wr_req[k] || granted[k]) begin
          wr_req[k] = ($urandom_range(0, 9) < 6);
          wr_addr[k*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 8191))
                                                          : AW'($urandom_range(0, DEPTH - 1));
          wr_data[k*DW +: DW] = DW'($urandom_range(0, 7));
        end else if ($urandom_range(0, 19) == 0) begin
          wr_req[k] = 1'b0;
        end
      end
      vid_rd_en = ($urandom_range(0, 3) == 0);
      vid_addr  = AW'($urandom_range(0, DEPTH - 1));
      #3;
      model_eval();
      total++;
      if ({wr_gnt, ram_write, ram_addr, ram_wdata, clr_busy, clr_done} !==
          {e_gnt, e_wr, e_addr, e_wd, m_clear, m_done}) begin
        bad++;
        $display("FAIL random c=%0d req=%b vid=%b got gnt=%b wr=%b addr=%0d wd=%0d exp gnt=%b wr=%b addr=%0d wd=%0d",
                 c, wr_req, vid_rd_en, wr_gnt, ram_write, ram_addr, ram_wdata, e_gnt, e_wr, e_addr, e_wd);
      end
`ifdef FRAME_WR_BOUNDS_CHK_EN
      total++;
      if (wr_oob !== e_oob) begin
        bad++;
        $display("FAIL random_oob c=%0d got=%b exp=%b", c, wr_oob, e_oob);
      end
`endif
      if (wr_gnt !== 3'b000) begin
        automatic int gk = wr_gnt[0] ? 0 : (wr_gnt[1] ? 1 : 2);
        total++;
        if (gk == last_k && (wr_req & ~wr_gnt) != 3'b000) begin
          bad++;
          $display("FAIL fairness c=%0d got repeat grant=%0d exp other of req=%b", c, gk, wr_req);
        end
        last_k = gk;
      end
      granted = wr_gnt;
      model_commit();
      @(posedge px_clk); #1;
    end
    wr_req    = 3'b000;
    vid_rd_en = 1'b0;
  endtask

`ifdef FRAME_WR_BOUNDS_CHK_EN
  task automatic test_oob();
    wr_req    = 3'b100;
    wr_addr   = {AW'(4800), AW'(0), AW'(0)};
    wr_data   = {DW'(7), DW'(0), DW'(0)};
    vid_rd_en = 1'b0;
    #3;
    model_eval();
    total++;
    if (wr_gnt !== 3'b100 || wr_oob !== 1'b1 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL oob got gnt=%b oob=%b wr=%b exp gnt=100 oob=1 wr=0", wr_gnt, wr_oob, ram_write);
    end
    model_commit();
    @(posedge px_clk); #1;
    wr_req = 3'b000;
    #3;
    total++;
    if (wr_oob !== 1'b0) begin
      bad++;
      $display("FAIL oob_pulse got=%b exp=0", wr_oob);
    end
    model_eval();
    model_commit();
    @(posedge px_clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_rr();
    test_video_block();
    test_clear_pending();
    test_random();
`ifdef FRAME_WR_BOUNDS_CHK_EN
    test_oob();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
